// File: rtl/phv_deparser_if.sv
// ---------------------------------------------------------------------------
// phv_deparser_if
//
// AXI-Stream bundle used on both sides of the deparser.
//
// Handshake: a beat transfers on a rising clock edge where tvalid && tready.
// Once tvalid is raised it stays high, with tdata/tuser/tkeep/tlast unchanged,
// until that transfer happens. tready may change freely and may depend
// combinationally on tvalid.
//
// Signals:
//   tdata  [DATA_W-1:0]    payload, byte n of the beat in tdata[8n+7 -: 8]
//   tuser  [USER_W-1:0]    sideband
//   tkeep  [DATA_W/8-1:0]  byte-lane enables
//   tvalid                 source has a beat
//   tlast                  last beat of the packet
//   tready                 sink accepts the beat
// Modports:
//   master : drives the beat, receives tready
//   slave  : receives the beat, drives tready
// ---------------------------------------------------------------------------
interface phv_deparser_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [USER_W-1:0]   tuser;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (
    output tdata,
    output tuser,
    output tkeep,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tuser,
    input  tkeep,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/phv_deparser.sv
// ---------------------------------------------------------------------------
// phv_deparser
//
// Transmit-side deparser. It takes one PHV per packet and writes the header
// containers that the deparse action list selects back into the first 128
// bytes of the matching original packet. The rebuilt packet leaves through a
// registered master AXI-Stream.
//
// Optional feature macro: PHV_DISCARD_EN. When it is defined and bit 128 of
// the latched PHV is set, the packet is consumed and nothing is emitted.
//
// Ports:
//   axis_clk       sole clock
//   areset         synchronous, active-high reset
//   phv_in         header vector, PKT_HDR_LEN bits
//   phv_valid_in   PHV strobe
//   phv_ready_out  high while idle; PHV latched on valid && ready
//   deparse_act    10 x 16-bit static action entries
//   s_axis         original packet in (slave modport)
//   m_axis         rebuilt packet out (master modport)
//   state_dbg      current FSM state (0 idle, 1 wait_pkt, 2 hdr, 3 body)
// ---------------------------------------------------------------------------
module phv_deparser #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int PKT_HDR_LEN          = (6+4+2)*8*8+20*5+256,
  parameter int DEPARSE_ACT_WIDTH    = 160
) (
  input  logic                         axis_clk,
  input  logic                         areset,
  input  logic [PKT_HDR_LEN-1:0]       phv_in,
  input  logic                         phv_valid_in,
  output logic                         phv_ready_out,
  input  logic [DEPARSE_ACT_WIDTH-1:0] deparse_act,
  phv_deparser_if.slave                s_axis,
  phv_deparser_if.master               m_axis,
  output logic [1:0]                   state_dbg
);

  localparam int NUM_ENT = DEPARSE_ACT_WIDTH / 16;
  localparam int BYTES   = C_S_AXIS_DATA_WIDTH / 8;
  // Top bit positions of the 6B, 4B and 2B container banks.
  localparam int C6_TOP  = PKT_HDR_LEN - 1;
  localparam int C4_TOP  = PKT_HDR_LEN - 1 - 8*48;
  localparam int C2_TOP  = PKT_HDR_LEN - 1 - 8*48 - 8*32;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_PKT = 2'd1,
    S_HDR      = 2'd2,
    S_BODY     = 2'd3
  } state_t;

  state_t                         state;
  state_t                         state_next;
  logic [PKT_HDR_LEN-1:0]         phv_q;
  logic [1:0]                     beat_k;
  logic                           s_ready;
  logic                           s_acc;
  logic                           phv_acc;
  logic                           discard;
  logic [C_S_AXIS_DATA_WIDTH-1:0] sub_data;

  assign state_dbg = state;

  `ifdef PHV_DISCARD_EN
  assign discard = phv_q[128];
  `else
  assign discard = 1'b0;
  `endif

  // Parse bits, metadata above the tuser slice, reserved action bits and the
  // incoming tuser do not affect the output.
  logic unused_sig;
  assign unused_sig = ^{phv_q[255:128], phv_q[C2_TOP-128:256], s_axis.tuser, deparse_act};

  // ---------------------------------------------------------------------------
  // Container banks, split out with constant selects.
  // ---------------------------------------------------------------------------
  logic [47:0] c6 [8];
  logic [31:0] c4 [8];
  logic [15:0] c2 [8];

  for (genvar i = 0; i < 8; i++) begin : g_cont
    assign c6[i] = phv_q[C6_TOP - 48*i -: 48];
    assign c4[i] = phv_q[C4_TOP - 32*i -: 32];
    assign c2[i] = phv_q[C2_TOP - 16*i -: 16];
  end

  // ---------------------------------------------------------------------------
  // Action decode: per entry a byte range [lo, hi) and the container bytes in
  // network order (byte 0 = container MSB). Slots 6 and 7 are never selected
  // but keep the 3-bit byte index in range.
  // ---------------------------------------------------------------------------
  logic       ent_en   [NUM_ENT];
  logic [7:0] ent_lo   [NUM_ENT];
  logic [7:0] ent_hi   [NUM_ENT];
  logic [7:0] ent_byte [NUM_ENT][8];

  always_comb begin
    logic [15:0] ent;
    logic [47:0] val;
    logic [7:0]  size;
    ent  = '0;
    val  = '0;
    size = '0;
    for (int e = 0; e < NUM_ENT; e++) begin
      ent  = deparse_act[16*e +: 16];
      val  = '0;
      size = 8'd0;
      case (ent[14:13])
        2'b01:   begin val = {c2[ent[12:10]], 32'h0}; size = 8'd2; end
        2'b10:   begin val = {c4[ent[12:10]], 16'h0}; size = 8'd4; end
        2'b11:   begin val = c6[ent[12:10]];          size = 8'd6; end
        default: begin val = '0;                      size = 8'd0; end
      endcase
      ent_en[e] = ent[15] && (ent[14:13] != 2'b00);
      ent_lo[e] = {1'b0, ent[9:3]};
      ent_hi[e] = ent_lo[e] + size;
      for (int d = 0; d < 6; d++) begin
        ent_byte[e][d] = val[47 - 8*d -: 8];
      end
      ent_byte[e][6] = 8'h00;
      ent_byte[e][7] = 8'h00;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte substitution for the current header beat. Entries are scanned in
  // ascending order so the highest matching index is the last to write.
  // Positions above 127 never occur in HDR, which truncates long containers.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [7:0] pos;
    logic [2:0] diff;
    pos      = '0;
    diff     = '0;
    sub_data = s_axis.tdata;
    if (state == S_HDR) begin
      for (int j = 0; j < BYTES; j++) begin
        pos = {1'b0, beat_k, 5'(j)};
        for (int e = 0; e < NUM_ENT; e++) begin
          if (ent_en[e] && (pos >= ent_lo[e]) && (pos < ent_hi[e])) begin
            diff = 3'(pos - ent_lo[e]);
            sub_data[8*j +: 8] = ent_byte[e][diff];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge axis_clk) begin
    if (areset) state <= S_IDLE;
    else        state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (phv_valid_in)          state_next = S_WAIT_PKT;
      S_WAIT_PKT: if (s_axis.tvalid)         state_next = S_HDR;
      S_HDR: begin
        if (s_acc && s_axis.tlast)           state_next = S_IDLE;
        else if (s_acc && beat_k == 2'd3)    state_next = S_BODY;
      end
      S_BODY:     if (s_acc && s_axis.tlast) state_next = S_IDLE;
      default:                               state_next = S_IDLE;
    endcase
  end

  // FSM: outputs. Input is accepted only when the output register is free or
  // draining this cycle, so a loaded beat is never overwritten.
  always_comb begin
    phv_ready_out = (state == S_IDLE);
    s_ready       = ((state == S_HDR) || (state == S_BODY)) &&
                    (!m_axis.tvalid || m_axis.tready);
  end

  assign s_axis.tready = s_ready;
  assign s_acc         = s_axis.tvalid && s_ready;
  assign phv_acc       = phv_valid_in && phv_ready_out;

  // ---------------------------------------------------------------------------
  // Datapath: PHV latch, header beat counter and output register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      phv_q         <= '0;
      beat_k        <= 2'd0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tuser  <= '0;
      m_axis.tkeep  <= '0;
      m_axis.tlast  <= 1'b0;
    end else begin
      if (phv_acc) phv_q <= phv_in;

      // Counter wraps 3 -> 0 on entry to BODY and is held there afterwards.
      if (s_acc) begin
        if (s_axis.tlast)        beat_k <= 2'd0;
        else if (state == S_HDR) beat_k <= beat_k + 2'd1;
      end

      if (s_acc && !discard) begin
        m_axis.tvalid <= 1'b1;
        m_axis.tdata  <= sub_data;
        m_axis.tuser  <= phv_q[C_S_AXIS_TUSER_WIDTH-1:0];
        m_axis.tkeep  <= s_axis.tkeep;
        m_axis.tlast  <= s_axis.tlast;
      end else if (m_axis.tready) begin
        m_axis.tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_phv_deparser.sv
// ---------------------------------------------------------------------------
// tb_phv_deparser
//
// Directed and randomized packets through phv_deparser. Expected beats come
// from a byte-array model that paints each action's container into the packet
// in entry order, then regroups the bytes into beats.
// ---------------------------------------------------------------------------
module tb_phv_deparser;

  localparam int DW   = 256;
  localparam int UW   = 128;
  localparam int KW   = 32;
  localparam int PW   = 1124;
  localparam int AW   = 160;
  localparam int W    = DW + UW + KW + 1;
  localparam int MAXB = 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] phv_in;
  logic          phv_valid_in;
  logic          phv_ready_out;
  logic [AW-1:0] deparse_act;
  logic [1:0]    state_dbg;

  phv_deparser_if #(.DATA_W(DW), .USER_W(UW)) s_axis ();
  phv_deparser_if #(.DATA_W(DW), .USER_W(UW)) m_axis ();

  phv_deparser dut (
    .axis_clk      (clk),
    .areset        (rst),
    .phv_in        (phv_in),
    .phv_valid_in  (phv_valid_in),
    .phv_ready_out (phv_ready_out),
    .deparse_act   (deparse_act),
    .s_axis        (s_axis),
    .m_axis        (m_axis),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
  int rdy_mode = 0;
  int rdy_cyc  = 0;
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1:       m_axis.tready = ((rdy_cyc % 4) == 0) || ((rdy_cyc % 4) == 3);
      2:       m_axis.tready = 1'($urandom_range(0, 1));
      default: m_axis.tready = 1'b1;
    endcase
    rdy_cyc++;
  end

  // ---------------- shared state ----------------
  int             n_checks = 0;
  int             n_fail   = 0;
  logic [PW-1:0]  cur_phv;
  logic [AW-1:0]  cur_act;
  logic [DW-1:0]  beat_d[$];
  logic [KW-1:0]  beat_keep[$];
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   got_q[$];
  bit             drv_done;
  int             stab_err;
  int             bp_err;
  int             hold_err;
  int             drv_tmo;
  logic           last_idle_rdy;

  // ---------------- stimulus builders ----------------
  task automatic rand_phv();
    for (int i = 0; i < PW; i++) cur_phv[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic rand_act();
    logic [15:0] ent;
    for (int e = 0; e < 10; e++) begin
      ent     = 16'($urandom);
      ent[15] = ($urandom_range(0, 3) != 0);
      ent[9:3] = 7'($urandom_range(0, 80));
      cur_act[16*e +: 16] = ent;
    end
  endtask

  task automatic make_pkt(input int n, input bit zero, input logic [KW-1:0] last_keep);
    logic [DW-1:0] d;
    beat_d.delete();
    beat_keep.delete();
    for (int k = 0; k < n; k++) begin
      d = '0;
      if (!zero) for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
      beat_d.push_back(d);
      beat_keep.push_back((k == n - 1) ? last_keep : {KW{1'b1}});
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void build_exp();
    logic [7:0]  pb [32*MAXB];
    logic [15:0] ent;
    logic [47:0] cv;
    logic [DW-1:0] d;
    int n, sz, idx, off, pos;
    n = beat_d.size();
    exp_q.delete();
    for (int k = 0; k < n; k++)
      for (int j = 0; j < 32; j++) pb[32*k + j] = beat_d[k][8*j +: 8];
    for (int e = 0; e < 10; e++) begin
      ent = cur_act[16*e +: 16];
      if (ent[15] && ent[14:13] != 2'b00) begin
        sz  = 2 * int'(ent[14:13]);
        idx = int'(ent[12:10]);
        off = int'(ent[9:3]);
        case (ent[14:13])
          2'b11:   cv = cur_phv[1123 - 48*idx -: 48];
          2'b10:   cv = {16'h0, cur_phv[739 - 32*idx -: 32]};
          default: cv = {32'h0, cur_phv[483 - 16*idx -: 16]};
        endcase
        for (int b = 0; b < sz; b++) begin
          pos = off + b;
          if (pos < 128 && pos < 32*n) pb[pos] = cv[8*(sz - 1 - b) +: 8];
        end
      end
    end
    `ifdef PHV_DISCARD_EN
    if (cur_phv[128]) return;
    `endif
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 32; j++) d[8*j +: 8] = pb[32*k + j];
      exp_q.push_back({d, cur_phv[127:0], beat_keep[k], 1'(k == n - 1)});
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_pkt(input int abort_at);
    int  tmo;
    int  acc;
    bit  stop;
    acc  = 0;
    stop = 0;
    @(negedge clk);
    phv_in       = cur_phv;
    phv_valid_in = 1'b1;
    tmo = 0;
    while (!phv_ready_out && tmo < 200) begin @(negedge clk); tmo++; end
    if (tmo >= 200) begin
      n_checks++; n_fail++; drv_tmo++;
      $display("FAIL phv_accept_timeout: phv_ready_out stayed %b, want 1", phv_ready_out);
    end
    @(negedge clk);
    phv_valid_in = 1'b0;
    for (int i = 0; i < beat_d.size() && !stop; i++) begin
      s_axis.tdata  = beat_d[i];
      s_axis.tkeep  = beat_keep[i];
      s_axis.tlast  = (i == beat_d.size() - 1);
      s_axis.tuser  = {$urandom, $urandom, $urandom, $urandom};
      s_axis.tvalid = 1'b1;
      tmo = 0;
      while (!s_axis.tready && tmo < 500) begin
        if (phv_ready_out) hold_err++;
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 500) begin
        n_checks++; n_fail++; drv_tmo++;
        $display("FAIL beat_accept_timeout: beat %0d s_axis_tready stayed 0, want 1", i);
        stop = 1;
      end else begin
        if (phv_ready_out) hold_err++;
        @(negedge clk);
        acc++;
        if (acc == abort_at) begin
          rst           = 1'b1;
          s_axis.tvalid = 1'b0;
          @(negedge clk);
          rst  = 1'b0;
          stop = 1;
        end
      end
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    last_idle_rdy = phv_ready_out;
    drv_done      = 1'b1;
  endtask

  task automatic capture();
    int         idle;
    int         tmo;
    bit         have_held;
    logic [W-1:0] held;
    logic [W-1:0] cur;
    idle = 0; tmo = 0; have_held = 0; held = '0;
    got_q.delete();
    while (idle < 10 && tmo < 5000) begin
      @(negedge clk);
      tmo++;
      if (drv_done && !m_axis.tvalid) idle++;
      if (m_axis.tvalid) begin
        cur = {m_axis.tdata, m_axis.tuser, m_axis.tkeep, m_axis.tlast};
        if (have_held && cur !== held) stab_err++;
        if (!m_axis.tready && s_axis.tready) bp_err++;
        if (m_axis.tready) begin got_q.push_back(cur); have_held = 0; end
        else begin held = cur; have_held = 1; end
      end else begin
        if (have_held) stab_err++;
        have_held = 0;
      end
    end
    if (tmo >= 5000) begin
      n_checks++; n_fail++;
      $display("FAIL capture_timeout: output still active after %0d cycles, want drained", tmo);
    end
  endtask

  task automatic run_pkt();
    deparse_act = cur_act;
    build_exp();
    drv_done = 1'b0; stab_err = 0; bp_err = 0; hold_err = 0; drv_tmo = 0;
    fork
      drive_pkt(-1);
      capture();
    join
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (m_axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_axis.tvalid); end
    n_checks++; if (m_axis.tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", m_axis.tdata); end
    n_checks++; if (m_axis.tuser !== '0) begin n_fail++; $display("FAIL reset_tuser: got %h want 0", m_axis.tuser); end
    n_checks++; if (m_axis.tkeep !== '0) begin n_fail++; $display("FAIL reset_tkeep: got %h want 0", m_axis.tkeep); end
    n_checks++; if (m_axis.tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", m_axis.tlast); end
    n_checks++; if (phv_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_phv_ready: got %b want 1", phv_ready_out); end
    n_checks++; if (s_axis.tready !== 1'b0) begin n_fail++; $display("FAIL reset_s_tready: got %b want 0", s_axis.tready); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_rewrite();
    logic [DW-1:0] d;
    rand_phv();
    cur_phv[1123 -: 48] = 48'hAABBCCDDEEFF;
    cur_phv[128] = 1'b0;
    cur_act = '0;
    cur_act[15:0] = 16'hE000;
    make_pkt(2, 1'b1, {KW{1'b1}});
    rdy_mode = 0;
    run_pkt();
    n_checks++;
    if (got_q.size() !== 2) begin n_fail++; $display("FAIL single_count: got %0d beats want 2", got_q.size()); end
    if (got_q.size() >= 2) begin
      d = got_q[0][W-1 -: DW];
      n_checks++; if (d[47:0] !== 48'hFFEEDDCCBBAA) begin n_fail++; $display("FAIL single_bytes0_5: got %h want ffeeddccbbaa", d[47:0]); end
      n_checks++; if (d[DW-1:48] !== '0) begin n_fail++; $display("FAIL single_rest_beat0: got %h want 0", d[DW-1:48]); end
      d = got_q[1][W-1 -: DW];
      n_checks++; if (d !== '0) begin n_fail++; $display("FAIL single_beat1: got %h want 0", d); end
      n_checks++; if (got_q[0][W-1-DW -: UW] !== cur_phv[127:0]) begin n_fail++; $display("FAIL single_tuser: got %h want %h", got_q[0][W-1-DW -: UW], cur_phv[127:0]); end
      n_checks++; if (got_q[1][0] !== 1'b1) begin n_fail++; $display("FAIL single_tlast: got %b want 1", got_q[1][0]); end
    end
  endtask

  task automatic test_straddle();
    rand_phv();
    cur_phv[675:644] = 32'h11223344;
    cur_phv[128] = 1'b0;
    cur_act = '0;
    cur_act[15:0] = 16'hC8F0;
    make_pkt(2, 1'b1, {KW{1'b1}});
    rdy_mode = 0;
    run_pkt();
    n_checks++;
    if (got_q.size() !== 2) begin n_fail++; $display("FAIL straddle_count: got %0d beats want 2", got_q.size()); end
    if (got_q.size() >= 2) begin
      n_checks++; if (got_q[0][W-1 -: 16] !== 16'h2211) begin n_fail++; $display("FAIL straddle_beat0: got %h want 2211", got_q[0][W-1 -: 16]); end
      n_checks++; if (got_q[1][W-DW+15 -: 16] !== 16'h4433) begin n_fail++; $display("FAIL straddle_beat1: got %h want 4433", got_q[1][W-DW+15 -: 16]); end
    end
  endtask

  task automatic test_overlap();
    logic [DW-1:0] d;
    rand_phv();
    cur_phv[467:452] = 16'h5555;
    cur_phv[419:404] = 16'h9999;
    cur_phv[128] = 1'b0;
    cur_act = '0;
    cur_act[31:16] = 16'hA450;
    cur_act[63:48] = 16'hB050;
    make_pkt(2, 1'b0, {KW{1'b1}});
    rdy_mode = 0;
    run_pkt();
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL overlap_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    if (got_q.size() >= 1) begin
      d = got_q[0][W-1 -: DW];
      n_checks++; if (d[95:80] !== 16'h9999) begin n_fail++; $display("FAIL overlap_bytes10_11: got %h want 9999", d[95:80]); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL overlap_beat%0d: got %h want %h", i, got_q[i][W-1 -: DW], exp_q[i][W-1 -: DW]); end
    end
  endtask

  task automatic test_backpressure();
    rand_phv();
    cur_phv[128] = 1'b0;
    rand_act();
    make_pkt(10, 1'b0, {KW{1'b1}});
    rdy_mode = 1;
    run_pkt();
    rdy_mode = 0;
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stab_err); end
    n_checks++; if (bp_err !== 0) begin n_fail++; $display("FAIL bp_s_tready: got %0d cycles ready while full want 0", bp_err); end
    n_checks++; if (hold_err !== 0) begin n_fail++; $display("FAIL bp_phv_holdoff: got %0d busy cycles with phv_ready want 0", hold_err); end
  endtask

  task automatic test_short();
    rand_phv();
    cur_phv[128] = 1'b0;
    rand_act();
    make_pkt(1, 1'b0, 32'h0000FFFF);
    rdy_mode = 0;
    run_pkt();
    n_checks++;
    if (got_q.size() !== 1) begin n_fail++; $display("FAIL short_count: got %0d beats want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_checks++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL short_beat: got %h want %h", got_q[0], exp_q[0]); end
      n_checks++; if (got_q[0][KW:1] !== 32'h0000FFFF) begin n_fail++; $display("FAIL short_tkeep: got %h want 0000ffff", got_q[0][KW:1]); end
      n_checks++; if (got_q[0][0] !== 1'b1) begin n_fail++; $display("FAIL short_tlast: got %b want 1", got_q[0][0]); end
    end
    n_checks++; if (last_idle_rdy !== 1'b1) begin n_fail++; $display("FAIL short_idle_after_last: phv_ready got %b want 1", last_idle_rdy); end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 6; p++) begin
      rand_phv();
      rand_act();
      make_pkt($urandom_range(1, 9), 1'b0, 32'($urandom));
      rdy_mode = (p < 2) ? 0 : 2;
      run_pkt();
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count p%0d: got %0d beats want %0d", p, got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_beat p%0d b%0d: got %h want %h", p, i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (stab_err !== 0 || bp_err !== 0) begin n_fail++; $display("FAIL b2b_handshake p%0d: got stab=%0d bp=%0d want 0", p, stab_err, bp_err); end
    end
    rdy_mode = 0;
  endtask

  task automatic test_reset_mid_body();
    rand_phv();
    cur_phv[128] = 1'b0;
    rand_act();
    make_pkt(10, 1'b0, {KW{1'b1}});
    rdy_mode = 0;
    deparse_act = cur_act;
    drv_done = 1'b0;
    drive_pkt(6);
    n_checks++; if (m_axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL midreset_tvalid: got %b want 0", m_axis.tvalid); end
    n_checks++; if (phv_ready_out !== 1'b1) begin n_fail++; $display("FAIL midreset_phv_ready: got %b want 1", phv_ready_out); end
    n_checks++; if (m_axis.tdata !== '0) begin n_fail++; $display("FAIL midreset_tdata: got %h want 0", m_axis.tdata); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL midreset_state: got %0d want 0", state_dbg); end
    // A fresh packet right after must come through intact.
    rand_phv();
    cur_phv[128] = 1'b0;
    make_pkt(5, 1'b0, {KW{1'b1}});
    run_pkt();
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL midreset_recover_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midreset_recover_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  `ifdef PHV_DISCARD_EN
  task automatic test_discard();
    rand_phv();
    cur_phv[128] = 1'b1;
    rand_act();
    make_pkt(7, 1'b0, {KW{1'b1}});
    rdy_mode = 2;
    run_pkt();
    rdy_mode = 0;
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL discard_count: got %0d beats want 0", got_q.size()); end
    n_checks++; if (drv_tmo !== 0) begin n_fail++; $display("FAIL discard_drain: got %0d stalls want 0", drv_tmo); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL discard_state: got %0d want 0", state_dbg); end
  endtask
  `endif

  // ---------------- sequence + report ----------------
  initial begin
    phv_in        = '0;
    phv_valid_in  = 1'b0;
    deparse_act   = '0;
    cur_act       = '0;
    cur_phv       = '0;
    s_axis.tdata  = '0;
    s_axis.tuser  = '0;
    s_axis.tkeep  = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    test_reset();
    test_single_rewrite();
    test_straddle();
    test_overlap();
    test_backpressure();
    test_short();
    test_back_to_back();
    test_reset_mid_body();
    `ifdef PHV_DISCARD_EN
    test_discard();
    `endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/phv_deparser.md
# phv_deparser

Transmit-side counterpart of the header parser. It accepts one packet header vector (PHV) per packet, plus the matching original packet as a 256-bit AXI-Stream. It writes the PHV's header containers back into the first 128 bytes of the packet and emits the rebuilt packet on a master AXI-Stream. It sits at the pipeline tail, after the last match-action stage and the packet-body cache, and in front of the output MAC.

## Interface
- C_S_AXIS_DATA_WIDTH, 256: stream data width; fixed at 32 bytes per beat.
- C_S_AXIS_TUSER_WIDTH, 128: tuser width.
- PKT_HDR_LEN, (6+4+2)*8*8+20*5+256 = 1124: PHV width.
- DEPARSE_ACT_WIDTH, 160: deparse action list, 10 entries of 16 bits.
- axis_clk  in  1  sole clock.
- areset  in  1  reset. One clock; reset is synchronous and active-high.
- phv_in  in  PKT_HDR_LEN  header vector.
- phv_valid_in  in  1  PHV strobe.
- phv_ready_out  out  1  high in IDLE. PHV is accepted when phv_valid_in && phv_ready_out.
- deparse_act  in  DEPARSE_ACT_WIDTH  static configuration. Entry e is bits [16e+15:16e]: [15] valid, [14:13] type (01 = 2B, 10 = 4B, 11 = 6B, 00 = ignored), [12:10] container index, [9:3] byte offset 0..127, [2:0] reserved.
- s_axis_tdata / tuser / tkeep / tvalid / tlast  in  256/128/32/1/1  original packet.
- s_axis_tready  out  1.
- m_axis_tdata / tuser / tkeep / tvalid / tlast  out  256/128/32/1/1  rebuilt packet.
- m_axis_tready  in  1.

## Operation
- PHV layout, MSB first:
  - 8×48b containers; 6B index i at [1123-48i -: 48].
  - 8×32b containers; 4B index i at [739-32i -: 32].
  - 8×16b containers; 2B index i at [483-16i -: 16].
  - 100 parse bits (ignored).
  - 256 metadata bits at [255:0].
- Byte lane: packet byte b of beat k is tdata[8(b-32k)+7 -: 8]. Container bytes are network order: the container MSB lands at the lowest offset.
- FSM states:
  - IDLE: phv_ready_out=1. On PHV handshake, latch phv_in → WAIT_PKT.
  - WAIT_PKT: s_axis_tready=0. Go to HDR when s_axis_tvalid is high.
  - HDR: beat counter k=0..3. Each accepted beat is substituted: byte b is replaced when any valid entry satisfies offset ≤ b < offset+size. If several entries cover the same byte, the highest entry index wins. Containers may straddle beat boundaries. Offset+size > 128 truncates at byte 127.
    - tlast → IDLE.
    - k==3 without tlast → BODY.
  - BODY: pass through unchanged; tlast → IDLE.
- m_axis_tuser is the latched phv[127:0] on every beat; s_axis_tuser is discarded. tkeep and tlast pass through unchanged.
- Substitution ignores tkeep. Bytes in invalid lanes may be written, and tkeep is kept.

## Timing
- Output register: one cycle from the s_axis handshake to m_axis_tvalid.
- s_axis_tready = (state ∈ {HDR, BODY}) && (!m_axis_tvalid || m_axis_tready), combinational.
- m_axis_tvalid holds, with data stable, until m_axis_tready is high.
- Full throughput: one beat per cycle with m_axis_tready held high.
- PHV-to-first-output latency is 2 cycles minimum: latch cycle, then the first accepted beat, then the output register.
- Back-to-back packets: one IDLE cycle minimum between the tlast handshake and the next PHV acceptance.
- Reset values:
  - state=IDLE, phv_ready_out=1.
  - m_axis_tvalid=0; m_axis_tdata, tuser, tkeep and tlast all 0.
  - Latched PHV cleared to 0; k=0.
- Reset mid-packet abandons the packet. The remainder of the upstream packet is not skipped; upstream is reset by the same signal.
- A PHV presented while busy is held off (phv_ready_out=0) and is not dropped.

## Configuration
- PHV_DISCARD_EN defined: when latched phv[128]==1, the packet is consumed at full rate with s_axis_tready=1 in HDR/BODY. m_axis_tvalid stays 0 and the FSM returns to IDLE on tlast.
- PHV_DISCARD_EN undefined: phv[128] is ignored and every packet is emitted.

## Test plan
- Single rewrite: entry0 = valid, 6B, idx0, offset 0. PHV 6B container 0 = 0xAABBCCDDEEFF. 64-byte packet of 0x00 → output beat0 bytes 0..5 = AA BB CC DD EE FF, beat1 unchanged, tuser = phv[127:0].
- Straddle: 4B idx2 at offset 30 = 0x11223344 → beat0 bytes 30,31 = 11 22 and beat1 bytes 0,1 = 33 44.
- Overlap priority: entry1 2B 0x5555 at offset 10 and entry3 2B 0x9999 at offset 10 → bytes 10,11 = 99 99.
- Backpressure: 10-beat packet with m_axis_tready toggling 1,0,0,1 → every beat appears exactly once, in order, with data stable while stalled. s_axis_tready is low whenever the output register is full and m_axis_tready=0.
- Short packet: 1-beat packet with tlast and tkeep=0x0000FFFF → one output beat with tlast=1 and tkeep unchanged. FSM returns to IDLE, and the next PHV is accepted 1 cycle later.
- Reset mid-BODY: assert areset on beat 6 → next cycle m_axis_tvalid=0, phv_ready_out=1, tdata=0. With PHV_DISCARD_EN, phv[128]=1 → no output beats and s_axis drained.
